// File: rtl/queue_pointer_ctrl_if.sv
// Ingress, scheduler and status signals of the queue pointer controller.
// The controller connects through the slave modport and its driver through master.
interface queue_pointer_ctrl_if #(
  parameter int QID_W   = 2,
  parameter int INNER_W = 8
);
  localparam int NUM_Q  = 2 ** QID_W;
  localparam int ADDR_W = QID_W + INNER_W;

  logic               wr_valid;
  logic [QID_W-1:0]   wr_qid;
  logic               wr_eop;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic               wr_drop;
  logic               rd_req;
  logic [QID_W-1:0]   rd_qid;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [NUM_Q-1:0]   q_empty;
  logic [NUM_Q-1:0]   q_full;
  logic [INNER_W:0]   rd_words;

  modport master (
    output wr_valid, wr_qid, wr_eop, rd_req, rd_qid,
    input  wr_en, wr_addr, wr_drop, rd_en, rd_addr, q_empty, q_full, rd_words
  );

  modport slave (
    input  wr_valid, wr_qid, wr_eop, rd_req, rd_qid,
    output wr_en, wr_addr, wr_drop, rd_en, rd_addr, q_empty, q_full, rd_words
  );
endinterface

// File: rtl/queue_pointer_ctrl.sv
// Per-queue speculative/committed write and read pointers for a shared packet
// buffer; commits whole packets and rolls back packets that overflow their queue.
module queue_pointer_ctrl #(
  parameter int QID_W   = 2,
  parameter int INNER_W = 8
) (
  input logic                  clk,
  input logic                  reset,
  queue_pointer_ctrl_if.slave  bus
);
  localparam int NUM_Q = 2 ** QID_W;
  localparam int PTR_W = INNER_W + 1;
  localparam logic [PTR_W-1:0] DEPTH = {1'b1, {INNER_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, PKT, DROP} state_e;

  state_e             state_q, state_d;
  logic [QID_W-1:0]   cur_qid_q, cur_qid_d;
  logic               wr_drop_q, wr_drop_d;
  logic [PTR_W-1:0]   wp_s_q [NUM_Q];
  logic [PTR_W-1:0]   wp_s_d [NUM_Q];
  logic [PTR_W-1:0]   wp_c_q [NUM_Q];
  logic [PTR_W-1:0]   wp_c_d [NUM_Q];
  logic [PTR_W-1:0]   rp_q   [NUM_Q];
  logic [PTR_W-1:0]   rp_d   [NUM_Q];

  logic [QID_W-1:0]   q;
  logic               has_space;
  logic               wr_en;
  logic               rd_en;
  logic [NUM_Q-1:0]   q_empty;
  logic [NUM_Q-1:0]   q_full;

  always_comb begin
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      q_empty[i] = (rp_q[i] == wp_c_q[i]);
      q_full[i]  = ((wp_s_q[i] - rp_q[i]) == DEPTH);
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_qid_d = cur_qid_q;
    wr_drop_d = 1'b0;
    wp_s_d    = wp_s_q;
    wp_c_d    = wp_c_q;
    rp_d      = rp_q;
    wr_en     = 1'b0;

    q         = (state_q == IDLE) ? bus.wr_qid : cur_qid_q;
    // Space is judged against the pre-edge rp, so a same-cycle read frees room only next cycle.
    has_space = ((wp_s_q[q] - rp_q[q]) < DEPTH);

    if (bus.wr_valid) begin
      unique case (state_q)
        IDLE, PKT: begin
          cur_qid_d = q;
          if (has_space) begin
            wr_en     = 1'b1;
            wp_s_d[q] = wp_s_q[q] + 1'b1;
            if (bus.wr_eop) begin
              wp_c_d[q] = wp_s_q[q] + 1'b1;
              state_d   = IDLE;
            end else begin
              state_d   = PKT;
            end
          end else begin
            wp_s_d[q] = wp_c_q[q];
            wr_drop_d = 1'b1;
            state_d   = bus.wr_eop ? IDLE : DROP;
          end
        end
        DROP: begin
          if (bus.wr_eop) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    rd_en = bus.rd_req && !q_empty[bus.rd_qid];
    if (rd_en) rp_d[bus.rd_qid] = rp_q[bus.rd_qid] + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_qid_q <= '0;
      wr_drop_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_Q; i++) begin
        wp_s_q[i] <= '0;
        wp_c_q[i] <= '0;
        rp_q[i]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      cur_qid_q <= cur_qid_d;
      wr_drop_q <= wr_drop_d;
      wp_s_q    <= wp_s_d;
      wp_c_q    <= wp_c_d;
      rp_q      <= rp_d;
    end
  end

  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = {q, wp_s_q[q][INNER_W-1:0]};
  assign bus.wr_drop  = wr_drop_q;
  assign bus.rd_en    = rd_en;
  assign bus.rd_addr  = {bus.rd_qid, rp_q[bus.rd_qid][INNER_W-1:0]};
  assign bus.q_empty  = q_empty;
  assign bus.q_full   = q_full;
  assign bus.rd_words = wp_c_q[bus.rd_qid] - rp_q[bus.rd_qid];
endmodule
